mem_bus_arb: RTL

MEM_BUS_ARB -- requirements
Module: mem_bus_arb

---
 rtl/mem_bus_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arb.sv
// Single-owner arbiter sharing one memory command/response port between the
// ifmap-read, weight-read and omap-write requesters, with outstanding-command limiting.
module mem_bus_arb #(
  parameter int OST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        im_req,
  input  logic [31:0] im_addr,
  input  logic [31:0] im_wdata,
  input  logic        im_vld,
  output logic        im_rdy,
  output logic        im_rsp_vld,
  input  logic        im_rsp_rdy,
  output logic [31:0] im_rsp_data,

  input  logic        wt_req,
  input  logic [31:0] wt_addr,
  input  logic [31:0] wt_wdata,
  input  logic        wt_vld,
  output logic        wt_rdy,
  output logic        wt_rsp_vld,
  input  logic        wt_rsp_rdy,
  output logic [31:0] wt_rsp_data,

  input  logic        om_req,
  input  logic [31:0] om_addr,
  input  logic [31:0] om_wdata,
  input  logic        om_vld,
  output logic        om_rdy,
  output logic        om_rsp_vld,
  input  logic        om_rsp_rdy,
  output logic [31:0] om_rsp_data,

  output logic        mem_cmd_vld,
  input  logic        mem_cmd_rdy,
  output logic [31:0] mem_cmd_addr,
  output logic [31:0] mem_cmd_wdata,
  output logic        mem_cmd_wen,

  input  logic        mem_rsp_vld,
  output logic        mem_rsp_rdy,
  input  logic [31:0] mem_rsp_data,

  output logic [1:0]  owner,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_IM = 2'd1,
    OWN_WT = 2'd2,
    OWN_OM = 2'd3
  } state_t;

  localparam logic [2:0] OST_LIM = 3'(OST_MAX);

  state_t      state, state_nxt;
  logic [1:0]  last_owner, last_owner_nxt;
  logic [2:0]  ost, ost_nxt;
  logic        err_nxt;
  logic        room, sel_vld, sel_req, cmd_hs, rsp_hs;
  logic [1:0]  pick;

  // Round-robin choice: search starts with the requester after the last owner.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] reqs);
    logic [1:0] res;
    res = 2'd0;
    case (last)
      2'd1:    res = reqs[1] ? 2'd2 : reqs[2] ? 2'd3 : reqs[0] ? 2'd1 : 2'd0;
      2'd2:    res = reqs[2] ? 2'd3 : reqs[0] ? 2'd1 : reqs[1] ? 2'd2 : 2'd0;
      default: res = reqs[0] ? 2'd1 : reqs[1] ? 2'd2 : reqs[2] ? 2'd3 : 2'd0;
    endcase
    return res;
  endfunction

  assign room        = (ost < OST_LIM);
  assign owner       = state;
  assign im_rsp_data = mem_rsp_data;
  assign wt_rsp_data = mem_rsp_data;
  assign om_rsp_data = mem_rsp_data;
  assign pick        = rr_pick(last_owner, {om_req, wt_req, im_req});

  // Steer the owner's command and response handshakes onto the memory port.
  always_comb begin
    im_rdy        = 1'b0;
    wt_rdy        = 1'b0;
    om_rdy        = 1'b0;
    im_rsp_vld    = 1'b0;
    wt_rsp_vld    = 1'b0;
    om_rsp_vld    = 1'b0;
    sel_vld       = 1'b0;
    sel_req       = 1'b0;
    mem_cmd_addr  = 32'd0;
    mem_cmd_wdata = 32'd0;
    mem_rsp_rdy   = 1'b1;
    case (state)
      OWN_IM: begin
        sel_vld       = im_vld;
        sel_req       = im_req;
        mem_cmd_addr  = im_addr;
        mem_cmd_wdata = im_wdata;
        im_rdy        = mem_cmd_rdy & room;
        im_rsp_vld    = mem_rsp_vld;
        mem_rsp_rdy   = im_rsp_rdy;
      end
      OWN_WT: begin
        sel_vld       = wt_vld;
        sel_req       = wt_req;
        mem_cmd_addr  = wt_addr;
        mem_cmd_wdata = wt_wdata;
        wt_rdy        = mem_cmd_rdy & room;
        wt_rsp_vld    = mem_rsp_vld;
        mem_rsp_rdy   = wt_rsp_rdy;
      end
      OWN_OM: begin
        sel_vld       = om_vld;
        sel_req       = om_req;
        mem_cmd_addr  = om_addr;
        mem_cmd_wdata = om_wdata;
        om_rdy        = mem_cmd_rdy & room;
        om_rsp_vld    = mem_rsp_vld;
        mem_rsp_rdy   = om_rsp_rdy;
      end
      default: begin
        sel_vld = 1'b0;
      end
    endcase
    mem_cmd_vld = (state != IDLE) & sel_vld & room;
    mem_cmd_wen = (state == OWN_OM);
  end

  assign cmd_hs = mem_cmd_vld & mem_cmd_rdy;
  // A response with nothing outstanding is a protocol error and never decrements ost.
  assign rsp_hs = (state != IDLE) & mem_rsp_vld & mem_rsp_rdy & (ost != 3'd0);

  // Next-state, outstanding count and sticky error logic.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    ost_nxt        = ost;
    err_nxt        = err | (mem_rsp_vld & (ost == 3'd0));
    case ({cmd_hs, rsp_hs})
      2'b10:   ost_nxt = ost + 3'd1;
      2'b01:   ost_nxt = ost - 3'd1;
      default: ost_nxt = ost;
    endcase
    case (state)
      IDLE: begin
        if (pick != 2'd0) begin
          state_nxt      = state_t'(pick);
          last_owner_nxt = pick;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN_IM, OWN_WT, OWN_OM: begin
        if (!sel_req && (ost == 3'd0) && !cmd_hs) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, last owner, outstanding count and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 2'd3;
      ost        <= 3'd0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      ost        <= ost_nxt;
      err        <= err_nxt;
    end
  end

endmodule
